// File: rtl/uart_frame_parser.sv
// Frame delineator behind a UART receiver: SYNC, LEN, PAYLOAD[LEN], CHK.
// Good frames are buffered and replayed over a valid/ready byte stream.
module uart_frame_parser #(
  parameter int unsigned MAX_LEN      = 16,
  parameter int unsigned TIMEOUT_CLKS = 100000,
  parameter logic [7:0]  SYNC_BYTE    = 8'h7E
) (
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic       i_rx_dv,
  input  logic [7:0] i_rx_byte,
  output logic       o_pkt_valid,
  output logic [7:0] o_pkt_data,
  output logic       o_pkt_last,
  input  logic       i_pkt_ready,
  output logic [7:0] o_pkt_len,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic [1:0] o_err_code,
  output logic       o_drop,
  output logic       o_busy
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned TmoW = $clog2(TIMEOUT_CLKS) + 1;
  // The limit is reached on the edge where the counter would become TIMEOUT_CLKS-1.
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TIMEOUT_CLKS - 2);

  localparam logic [1:0] ErrLen = 2'd1;
  localparam logic [1:0] ErrTmo = 2'd2;
  localparam logic [1:0] ErrChk = 2'd3;

  typedef enum logic [2:0] {StSync, StLen, StPayload, StCheck, StOutput} state_e;

  state_e          state_q, state_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      sum_q, sum_d;
  logic [7:0]      wr_idx_q, wr_idx_d;
  logic [7:0]      rd_idx_q, rd_idx_d;
  logic [TmoW-1:0] idle_q, idle_d;
  logic            frame_ok_q, frame_ok_d;
  logic            frame_err_q, frame_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic            drop_q, drop_d;
  logic            wr_en;
  logic            timeout;
  logic            pkt_valid;
  logic            pkt_last;
  logic [7:0]      chk_sum;
  logic [7:0]      mem_q [MAX_LEN];

  assign pkt_valid = (state_q == StOutput);
  assign pkt_last  = pkt_valid && (rd_idx_q == len_q - 8'd1);
  assign timeout   = !i_rx_dv && (idle_q == TmoLimit);
  assign chk_sum   = sum_q + i_rx_byte;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    idle_d      = i_rx_dv ? '0 : idle_q + 1'b1;
    frame_ok_d  = 1'b0;
    frame_err_d = 1'b0;
    err_code_d  = err_code_q;
    drop_d      = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      StSync: begin
        idle_d = '0;
        if (i_rx_dv && i_rx_byte == SYNC_BYTE) state_d = StLen;
      end
      StLen: begin
        if (i_rx_dv) begin
          if (i_rx_byte == 8'd0 || 32'(i_rx_byte) > MAX_LEN) begin
            frame_err_d = 1'b1;
            err_code_d  = ErrLen;
            state_d     = StSync;
          end else begin
            len_d    = i_rx_byte;
            sum_d    = i_rx_byte;
            wr_idx_d = '0;
            state_d  = StPayload;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrTmo;
          state_d     = StSync;
        end
      end
      StPayload: begin
        if (i_rx_dv) begin
          wr_en    = 1'b1;
          sum_d    = chk_sum;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q == len_q - 8'd1) state_d = StCheck;
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrTmo;
          state_d     = StSync;
        end
      end
      StCheck: begin
        if (i_rx_dv) begin
          if (chk_sum == 8'd0) begin
            frame_ok_d = 1'b1;
            rd_idx_d   = '0;
            state_d    = StOutput;
          end else begin
            frame_err_d = 1'b1;
            err_code_d  = ErrChk;
            state_d     = StSync;
          end
        end else if (timeout) begin
          frame_err_d = 1'b1;
          err_code_d  = ErrTmo;
          state_d     = StSync;
        end
      end
      StOutput: begin
        idle_d = '0;
        // No re-sync while replaying: every incoming byte is discarded.
        drop_d = i_rx_dv;
        if (i_pkt_ready) begin
          if (pkt_last) begin
            rd_idx_d = '0;
            state_d  = StSync;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
          end
        end
      end
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StSync;
      len_q       <= '0;
      sum_q       <= '0;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      idle_q      <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      idle_q      <= idle_d;
      frame_ok_q  <= frame_ok_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      drop_q      <= drop_d;
    end
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) mem_q[wr_idx_q[IdxW-1:0]] <= i_rx_byte;
  end

  assign o_pkt_valid = pkt_valid;
  assign o_pkt_data  = pkt_valid ? mem_q[rd_idx_q[IdxW-1:0]] : 8'd0;
  assign o_pkt_last  = pkt_last;
  assign o_pkt_len   = len_q;
  assign o_frame_ok  = frame_ok_q;
  assign o_frame_err = frame_err_q;
  assign o_err_code  = err_code_q;
  assign o_drop      = drop_q;
  assign o_busy      = (state_q != StSync);

endmodule
